sumador_secuencial_ctrl: RTL and testbench



---
 rtl/sumador_pkg.sv | 17 +
 rtl/sumador_secuencial_ctrl_completo.sv | 16 +
 rtl/sumador_secuencial_ctrl.sv | 104 ++++++++++
 tb/tb_sumador_secuencial_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sumador_pkg.sv
// Shared definitions for the sequential slice adder: default geometry,
// index width helper and the controller state type.
package sumador_pkg;

  localparam int SUM_WIDTH = 4;
  localparam int SUM_WORDS = 4;

  // Keeps the slice index at least one bit wide even for degenerate geometries.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  localparam int SUM_IDX_W = idx_width(SUM_WORDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} sumador_state_t;

endpackage

// File: rtl/sumador_secuencial_ctrl_completo.sv
// WIDTH-bit full-adder slice, time-shared by the sequencer across all slices.
module Sumador_Completo
  import sumador_pkg::*;
#(
  parameter int WIDTH = SUM_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};

endmodule

// File: rtl/sumador_secuencial_ctrl.sv
// Multi-cycle add/subtract sequencer: one slice per clock, LSB slice first,
// with chained-carry or independent-lane (SIMD) operation.
module sumador_secuencial_ctrl
  import sumador_pkg::*;
#(
  parameter int WIDTH = SUM_WIDTH,
  parameter int WORDS = SUM_WORDS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   cin,
  input  logic                   simd,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   cout,
  output logic [WORDS-1:0]       lane_cout
);

  localparam int N     = WIDTH * WORDS;
  localparam int IDX_W = idx_width(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  sumador_state_t   state;
  logic [IDX_W-1:0] idx;
  logic [N-1:0]     a_r;
  logic [N-1:0]     b_r;
  logic             simd_r;
  logic             seed;
  logic             carry;

  logic [WIDTH-1:0] slice_a;
  logic [WIDTH-1:0] slice_b;
  logic [WIDTH-1:0] slice_s;
  logic             slice_ci;
  logic             slice_co;

  assign in_ready  = !rst && (state == IDLE);
  assign out_valid = (state == DONE);

  // SIMD lanes all restart from the seed; chained mode ripples the stored carry.
  assign slice_a  = a_r[idx*WIDTH +: WIDTH];
  assign slice_b  = b_r[idx*WIDTH +: WIDTH];
  assign slice_ci = simd_r ? seed : carry;

  Sumador_Completo #(.WIDTH(WIDTH)) u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (slice_ci),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      seed      <= 1'b0;
      simd_r    <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      lane_cout <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r    <= a;
            b_r    <= sub ? ~b : b;
            simd_r <= simd;
            seed   <= sub | cin;
            carry  <= sub | cin;
            idx    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          sum[idx*WIDTH +: WIDTH] <= slice_s;
          lane_cout[idx]          <= slice_co;
          carry                   <= slice_co;
          if (idx == LAST_IDX) begin
            cout  <= slice_co;
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sumador_secuencial_ctrl.sv
// Self-checking bench for sumador_secuencial_ctrl: directed vectors with literal
// expectations plus an arithmetic reference model checked every DONE cycle.
module tb_sumador_secuencial_ctrl;

  localparam int WIDTH = 4;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             cin;
  logic             simd;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     sum;
  logic             cout;
  logic [WORDS-1:0] lane_cout;

  int tests = 0;
  int fails = 0;

  logic             exp_valid = 1'b0;
  logic [N-1:0]     exp_sum;
  logic             exp_cout;
  logic [WORDS-1:0] exp_lane;

  sumador_secuencial_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .simd      (simd),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .lane_cout (lane_cout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    tests++;
    if (actual !== required) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  // Reference arithmetic: whole-word add for chained mode, per-lane add for SIMD.
  function automatic void model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                input logic mcin, input logic msimd, input logic msub,
                                output logic [N-1:0] s, output logic c,
                                output logic [WORDS-1:0] lc);
    bit [31:0] bb;
    bit [31:0] sd;
    bit [31:0] t;
    bit [31:0] m;
    s  = '0;
    lc = '0;
    c  = 1'b0;
    bb = msub ? {16'h0, ~mb} : {16'h0, mb};
    sd = (msub || mcin) ? 32'd1 : 32'd0;
    for (int i = 0; i < WORDS; i++) begin
      if (msimd) begin
        t = ((32'(ma) >> (i*WIDTH)) & 32'hF) + ((bb >> (i*WIDTH)) & 32'hF) + sd;
        s[i*WIDTH +: WIDTH] = t[3:0];
        lc[i] = t[4];
      end else begin
        m = (32'h1 << ((i+1)*WIDTH)) - 32'd1;
        t = (32'(ma) & m) + (bb & m) + sd;
        lc[i] = t[(i+1)*WIDTH];
      end
    end
    if (msimd) begin
      c = lc[WORDS-1];
    end else begin
      t = 32'(ma) + bb + sd;
      s = t[N-1:0];
      c = t[N];
    end
  endfunction

  // Compare process: tracks accepted operations and checks every DONE cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_valid = 1'b0;
    end else begin
      checkOutput("handshake_exclusive", 32'(in_ready & out_valid), 32'd0);
      if (out_valid) begin
        checkOutput("result_expected", 32'(exp_valid), 32'd1);
        if (exp_valid) begin
          checkOutput("model_sum", 32'(sum), 32'(exp_sum));
          checkOutput("model_cout", 32'(cout), 32'(exp_cout));
          checkOutput("model_lane_cout", 32'(lane_cout), 32'(exp_lane));
        end
        if (out_ready) exp_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        model(a, b, cin, simd, sub, exp_sum, exp_cout, exp_lane);
        exp_valid = 1'b1;
      end
    end
  end

  task automatic applyStimulus(input string name, input logic [N-1:0] va,
                               input logic [N-1:0] vb, input logic vcin,
                               input logic vsimd, input logic vsub, input int hold,
                               input logic [N-1:0] req_sum, input logic req_cout,
                               input logic [WORDS-1:0] req_lane);
    int lat;
    logic [N-1:0] held_sum;
    @(posedge clk);
    #1;
    a = va; b = vb; cin = vcin; simd = vsimd; sub = vsub; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, "_out_valid"}, 32'(out_valid), 32'd1);
    checkOutput({name, "_latency_edges"}, 32'(lat - 1), 32'(WORDS));
    checkOutput({name, "_sum"}, 32'(sum), 32'(req_sum));
    checkOutput({name, "_cout"}, 32'(cout), 32'(req_cout));
    checkOutput({name, "_lane_cout"}, 32'(lane_cout), 32'(req_lane));
    held_sum = sum;
    for (int i = 0; i < hold; i++) begin
      a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
      @(negedge clk);
      checkOutput({name, "_bp_out_valid"}, 32'(out_valid), 32'd1);
      checkOutput({name, "_bp_in_ready"}, 32'(in_ready), 32'd0);
      checkOutput({name, "_bp_sum_stable"}, 32'(sum), 32'(held_sum));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({name, "_release_in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({name, "_release_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; simd = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_sum", 32'(sum), 32'd0);
    checkOutput("reset_cout", 32'(cout), 32'd0);
    checkOutput("reset_lane_cout", 32'(lane_cout), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

    applyStimulus("add",        16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0, 16'hFFFF, 1'b0, 4'b0000);
    applyStimulus("add_carry",  16'h0001, 16'hFFFE, 1'b1, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 4'b1111);
    applyStimulus("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b0, 1'b1, 0, 16'hFFFE, 1'b0, 4'b0000);
    applyStimulus("sub_pos",    16'h0007, 16'h0005, 1'b0, 1'b0, 1'b1, 0, 16'h0002, 1'b1, 4'b1111);
    applyStimulus("simd_add",   16'h1F2E, 16'h1111, 1'b0, 1'b1, 1'b0, 0, 16'h203F, 1'b0, 4'b0100);
    applyStimulus("simd_sub",   16'h1234, 16'h1111, 1'b1, 1'b1, 1'b1, 0, 16'h0123, 1'b1, 4'b1111);
    applyStimulus("chain_bp",   16'h1F2E, 16'h1111, 1'b0, 1'b0, 1'b0, 5, 16'h303F, 1'b0, 4'b0100);

    // Abort an operation after two slices; partial results must vanish.
    @(posedge clk);
    #1;
    a = 16'h0001; b = 16'hFFFE; cin = 1'b0; simd = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrun_rst_sum", 32'(sum), 32'd0);
    checkOutput("midrun_rst_cout", 32'(cout), 32'd0);
    checkOutput("midrun_rst_lane_cout", 32'(lane_cout), 32'd0);
    checkOutput("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrun_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrun_idle_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrun_idle_out_valid", 32'(out_valid), 32'd0);
    applyStimulus("after_rst",  16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0, 16'hFFFF, 1'b0, 4'b0000);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
